bcd_display_sampler: RTL

Sequential binary-to-BCD converter between the MIPS datapath and the seven-segment decoders on the board top level. On request it snapshots NCH binary values (register-file taps and PC), converts each one serially by double-dabble, and presents hundreds/tens/units digits per channel. All channels update on the same cycle. It replaces the combinational `% 100 / 10` divider chain and removes the divider logic from the display path.

---
 rtl/bcd_display_sampler_pkg.sv | 20 ++
 rtl/bcd_display_sampler_dd_step.sv | 23 ++
 rtl/bcd_display_sampler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bcd_display_sampler_pkg.sv
// Shared types and helpers for the serial binary-to-BCD display sampler.
// Purely declarative: no timing or flow control lives here.
package bcd_pkg;

  localparam int BCD_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_COMMIT
  } state_e;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] add3_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_display_sampler_dd_step.sv
// One combinational double-dabble iteration: adjust all three BCD nibbles, then shift left one.
// Zero latency; no flow control (the caller sequences iterations).
module bcd_dd_step
  import bcd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [BCD_W+W-1:0] sr_in,
  output logic [BCD_W+W-1:0] sr_out
);

  logic [BCD_W-1:0]   adj;
  logic [BCD_W+W-1:0] pre;

  always_comb begin
    adj    = {add3_adjust(sr_in[W+8 +: 4]),
              add3_adjust(sr_in[W+4 +: 4]),
              add3_adjust(sr_in[W   +: 4])};
    pre    = {adj, sr_in[W-1:0]};
    sr_out = pre << 1;
  end

endmodule

// File: rtl/bcd_display_sampler.sv
// Snapshots NCH binary values on sample, converts each serially, commits all digits together.
// Latency NCH*(W+2)+2 cycles to visible digits; sample is ignored (not queued) while busy.
module bcd_display_sampler
  import bcd_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample,
  input  logic [NCH*W-1:0] vals,
  output logic [NCH*4-1:0] hund,
  output logic [NCH*4-1:0] tens,
  output logic [NCH*4-1:0] units,
  output logic             busy,
  output logic             done
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BIT_W = $clog2(W + 1);
  localparam int SR_W  = BCD_W + W;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_step;
  logic [NCH*W-1:0] snap_q, snap_d;
  logic [NCH*4-1:0] stg_hund_q, stg_hund_d;
  logic [NCH*4-1:0] stg_tens_q, stg_tens_d;
  logic [NCH*4-1:0] stg_units_q, stg_units_d;
  logic [NCH*4-1:0] hund_q, hund_d;
  logic [NCH*4-1:0] tens_q, tens_d;
  logic [NCH*4-1:0] units_q, units_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  bcd_dd_step #(.W(W)) u_step (
    .sr_in  (sr_q),
    .sr_out (sr_step)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    snap_d      = snap_q;
    stg_hund_d  = stg_hund_q;
    stg_tens_d  = stg_tens_q;
    stg_units_d = stg_units_q;
    hund_d      = hund_q;
    tens_d      = tens_q;
    units_d     = units_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sample) begin
          snap_d  = vals;
          ch_d    = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_d    = {{BCD_W{1'b0}}, snap_q[ch_q*W +: W]};
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_d  = sr_step;
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(W - 1)) begin
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        stg_hund_d[ch_q*4 +: 4]  = sr_q[W+8 +: 4];
        stg_tens_d[ch_q*4 +: 4]  = sr_q[W+4 +: 4];
        stg_units_d[ch_q*4 +: 4] = sr_q[W   +: 4];
        if (ch_q == CH_W'(NCH - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        // Only whole conversions reach the outputs; staging absorbs the per-channel writes.
        hund_d  = stg_hund_q;
        tens_d  = stg_tens_q;
        units_d = stg_units_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      snap_q      <= '0;
      stg_hund_q  <= '0;
      stg_tens_q  <= '0;
      stg_units_q <= '0;
      hund_q      <= '0;
      tens_q      <= '0;
      units_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      snap_q      <= snap_d;
      stg_hund_q  <= stg_hund_d;
      stg_tens_q  <= stg_tens_d;
      stg_units_q <= stg_units_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign hund  = hund_q;
  assign tens  = tens_q;
  assign units = units_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
